// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundle between the register-read stage and its neighbours
// (upstream issue, register file ports, writeback, execute).
// The stage itself uses the slave modport; its environment uses master.
interface operand_fetch_if;
  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;
  localparam int unsigned CntW  = 16;

  logic             InValid;
  logic             InReady;
  logic [DataW-1:0] Instruction;
  logic [AddrW-1:0] ReadRegister1;
  logic [AddrW-1:0] ReadRegister2;
  logic [DataW-1:0] ReadData1;
  logic [DataW-1:0] ReadData2;
  logic [AddrW-1:0] WriteRegister;
  logic [DataW-1:0] WriteData;
  logic             RegWrite;
  logic             ExLoadValid;
  logic [AddrW-1:0] ExLoadRegister;
  logic             OutValid;
  logic             OutReady;
  logic [DataW-1:0] OpA;
  logic [DataW-1:0] OpB;
  logic [DataW-1:0] OutInstruction;
  logic [CntW-1:0]  StallCount;

  modport master (
    output InValid, Instruction, ReadData1, ReadData2, WriteRegister,
           WriteData, RegWrite, ExLoadValid, ExLoadRegister, OutReady,
    input  InReady, ReadRegister1, ReadRegister2, OutValid, OpA, OpB,
           OutInstruction, StallCount
  );

  modport slave (
    input  InValid, Instruction, ReadData1, ReadData2, WriteRegister,
           WriteData, RegWrite, ExLoadValid, ExLoadRegister, OutReady,
    output InReady, ReadRegister1, ReadRegister2, OutValid, OpA, OpB,
           OutInstruction, StallCount
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: MIPS register-read stage. Reads rs/rt from the register file,
// resolves same-cycle writeback conflicts, stalls on load-use hazards and holds
// operands in a single-entry output register until execute takes them.
// Build option: define OPERAND_FETCH_BYPASS_EN to forward writeback data at
// accept; otherwise a writeback conflict stalls one cycle instead.
module operand_fetch (
  input logic            Clk,
  input logic            Reset_n,
  operand_fetch_if.slave bus
);
  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;
  localparam int unsigned CntW  = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stateT;

  stateT            state;
  logic [DataW-1:0] opA;
  logic [DataW-1:0] opB;
  logic [DataW-1:0] outInstruction;
  logic [CntW-1:0]  stallCount;

  logic [AddrW-1:0] rs;
  logic [AddrW-1:0] rt;
  logic [AddrW-1:0] heldRs;
  logic [AddrW-1:0] heldRt;
  logic             wbHitRs;
  logic             wbHitRt;
  logic             wbHitHeldRs;
  logic             wbHitHeldRt;
  logic             loadHazard;
  logic             hazard;
  logic             inReady;
  logic             accept;
  logic [DataW-1:0] fetchA;
  logic [DataW-1:0] fetchB;

  // Writeback hits a register only when enabled and the target is not r0.
  function automatic logic wbHit(input logic             regWrite,
                                 input logic [AddrW-1:0] writeRegister,
                                 input logic [AddrW-1:0] r);
    return regWrite && (writeRegister == r) && (r != AddrW'(0));
  endfunction

  assign rs     = bus.Instruction[25:21];
  assign rt     = bus.Instruction[20:16];
  assign heldRs = outInstruction[25:21];
  assign heldRt = outInstruction[20:16];

  assign bus.ReadRegister1 = rs;
  assign bus.ReadRegister2 = rt;

  assign wbHitRs     = wbHit(bus.RegWrite, bus.WriteRegister, rs);
  assign wbHitRt     = wbHit(bus.RegWrite, bus.WriteRegister, rt);
  assign wbHitHeldRs = wbHit(bus.RegWrite, bus.WriteRegister, heldRs);
  assign wbHitHeldRt = wbHit(bus.RegWrite, bus.WriteRegister, heldRt);

  // Both fields are compared regardless of opcode; r0 never creates a hazard.
  assign loadHazard = bus.ExLoadValid && (bus.ExLoadRegister != AddrW'(0)) &&
                      ((bus.ExLoadRegister == rs) || (bus.ExLoadRegister == rt));

`ifdef OPERAND_FETCH_BYPASS_EN
  assign hazard = loadHazard;
`else
  // Without forwarding, wait one cycle for the regfile to commit the write.
  assign hazard = loadHazard || wbHitRs || wbHitRt;
`endif

  assign inReady = ((state == EMPTY) || bus.OutReady) && !hazard;
  assign accept  = bus.InValid && inReady;

  // In the stalling build wbHit is never set on an accept, so this is shared.
  assign fetchA = (rs == AddrW'(0)) ? DataW'(0) : (wbHitRs ? bus.WriteData : bus.ReadData1);
  assign fetchB = (rt == AddrW'(0)) ? DataW'(0) : (wbHitRt ? bus.WriteData : bus.ReadData2);

  // Output register FSM: capture on accept, drain on OutReady, track writebacks while held.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= EMPTY;
      opA            <= '0;
      opB            <= '0;
      outInstruction <= '0;
      stallCount     <= '0;
    end else begin
      if (bus.InValid && hazard && (stallCount != {CntW{1'b1}})) begin
        stallCount <= stallCount + CntW'(1);
      end
      if (accept) begin
        state          <= FULL;
        opA            <= fetchA;
        opB            <= fetchB;
        outInstruction <= bus.Instruction;
      end else begin
        case (state)
          FULL: begin
            if (bus.OutReady) begin
              state <= EMPTY;
            end else begin
              if (wbHitHeldRs) opA <= bus.WriteData;
              if (wbHitHeldRt) opB <= bus.WriteData;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign bus.InReady        = inReady;
  assign bus.OutValid       = (state == FULL);
  assign bus.OpA            = opA;
  assign bus.OpB            = opB;
  assign bus.OutInstruction = outInstruction;
  assign bus.StallCount     = stallCount;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus a random stream, checked against a
// reference model with a scoreboard of expected output-register contents.
module tb_operand_fetch;
  logic Clk = 1'b0;
  logic Reset_n;

  operand_fetch_if ifc();

  operand_fetch dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (ifc)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
  } sbEntryT;

  sbEntryT     sbQ[$];
  logic [31:0] regs [32];
  logic        mValid;
  logic [15:0] mStall;
  logic        lastStalled;
  int          checks = 0;
  int          errors = 0;

  // Register file read ports are combinational.
  assign ifc.ReadData1 = regs[ifc.ReadRegister1];
  assign ifc.ReadData2 = regs[ifc.ReadRegister2];

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] tag);
    return {6'h23, rs, rt, tag};
  endfunction

  function automatic logic [4:0] pick(input int k);
    case (k)
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      3:       return 5'd10;
      default: return 5'd11;
    endcase
  endfunction

  function automatic logic wbHitM(input logic [4:0] r);
    return ifc.RegWrite && (ifc.WriteRegister == r) && (r != 5'd0);
  endfunction

  function automatic logic hazardM();
    logic [4:0] rs;
    logic [4:0] rt;
    logic       h;
    rs = ifc.Instruction[25:21];
    rt = ifc.Instruction[20:16];
    h  = ifc.ExLoadValid && (ifc.ExLoadRegister != 5'd0) &&
         ((ifc.ExLoadRegister == rs) || (ifc.ExLoadRegister == rt));
`ifndef OPERAND_FETCH_BYPASS_EN
    h = h || wbHitM(rs) || wbHitM(rt);
`endif
    return h;
  endfunction

  function automatic logic inReadyM();
    return (!mValid || ifc.OutReady) && !hazardM();
  endfunction

  function automatic logic [31:0] fetchM(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wbHitM(r)) return ifc.WriteData;
    return regs[r];
  endfunction

  // Reference model and register file: pushes expected captures on accept.
  always @(posedge Clk or negedge Reset_n) begin
    sbEntryT e;
    logic    hz;
    logic    rdy;
    if (!Reset_n) begin
      mValid      = 1'b0;
      mStall      = 16'h0;
      lastStalled = 1'b0;
      sbQ.delete();
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      regs[8]  <= 32'h11;
      regs[9]  <= 32'h22;
      regs[10] <= 32'h33;
      regs[11] <= 32'h44;
    end else begin
      hz          = hazardM();
      rdy         = inReadyM();
      lastStalled = ifc.InValid && !rdy;
      if (ifc.InValid && hz && (mStall != 16'hFFFF)) mStall = mStall + 16'd1;
      if (ifc.InValid && rdy) begin
        e.instr = ifc.Instruction;
        e.a     = fetchM(ifc.Instruction[25:21]);
        e.b     = fetchM(ifc.Instruction[20:16]);
        sbQ.push_back(e);
        mValid = 1'b1;
      end else if (mValid && ifc.OutReady) begin
        mValid = 1'b0;
      end else if (mValid && (sbQ.size() != 0)) begin
        e = sbQ[0];
        if (wbHitM(e.instr[25:21])) e.a = ifc.WriteData;
        if (wbHitM(e.instr[20:16])) e.b = ifc.WriteData;
        sbQ[0] = e;
      end
      if (ifc.RegWrite && (ifc.WriteRegister != 5'd0)) regs[ifc.WriteRegister] <= ifc.WriteData;
    end
  end

  // Mid-cycle monitor: handshake, counter and output register against the model.
  always @(negedge Clk) begin
    #3;
    if (Reset_n === 1'b1) begin
      checks++;
      if (ifc.InReady !== inReadyM()) begin
        errors++; $display("FAIL mon_inReady got %b expected %b at %0t", ifc.InReady, inReadyM(), $time);
      end
      checks++;
      if (ifc.OutValid !== mValid) begin
        errors++; $display("FAIL mon_outValid got %b expected %b at %0t", ifc.OutValid, mValid, $time);
      end
      checks++;
      if (ifc.StallCount !== mStall) begin
        errors++; $display("FAIL mon_stallCount got %0d expected %0d at %0t", ifc.StallCount, mStall, $time);
      end
      if (mValid) begin
        checks++;
        if (sbQ.size() == 0) begin
          errors++; $display("FAIL mon_scoreboard empty while output valid at %0t", $time);
        end else begin
          if ((ifc.OpA !== sbQ[0].a) || (ifc.OpB !== sbQ[0].b) || (ifc.OutInstruction !== sbQ[0].instr)) begin
            errors++;
            $display("FAIL mon_data got A=%h B=%h I=%h expected A=%h B=%h I=%h at %0t",
                     ifc.OpA, ifc.OpB, ifc.OutInstruction, sbQ[0].a, sbQ[0].b, sbQ[0].instr, $time);
          end
          if (ifc.OutReady) void'(sbQ.pop_front());
        end
      end
    end
  end

  task automatic idle();
    ifc.InValid        = 1'b0;
    ifc.Instruction    = 32'h0;
    ifc.RegWrite       = 1'b0;
    ifc.WriteRegister  = 5'd0;
    ifc.WriteData      = 32'h0;
    ifc.ExLoadValid    = 1'b0;
    ifc.ExLoadRegister = 5'd0;
    ifc.OutReady       = 1'b1;
  endtask

  task automatic nextCycle();
    @(negedge Clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    #1;
    checks++; if (ifc.OutValid !== 1'b0) begin errors++; $display("FAIL rst_outValid got %b expected 0", ifc.OutValid); end
    checks++; if (ifc.OpA !== 32'h0) begin errors++; $display("FAIL rst_opA got %h expected 0", ifc.OpA); end
    checks++; if (ifc.OpB !== 32'h0) begin errors++; $display("FAIL rst_opB got %h expected 0", ifc.OpB); end
    checks++; if (ifc.OutInstruction !== 32'h0) begin errors++; $display("FAIL rst_instr got %h expected 0", ifc.OutInstruction); end
    checks++; if (ifc.StallCount !== 16'h0) begin errors++; $display("FAIL rst_stall got %0d expected 0", ifc.StallCount); end
    checks++; if (ifc.InReady !== 1'b1) begin errors++; $display("FAIL rst_inReady got %b expected 1", ifc.InReady); end
    Reset_n = 1'b1;
  endtask

  task automatic test_basic();
    nextCycle();
    ifc.InValid = 1'b1; ifc.Instruction = mk(5'd8, 5'd9, 16'h1);
    #1;
    checks++; if (ifc.InReady !== 1'b1) begin errors++; $display("FAIL basic_inReady got %b expected 1", ifc.InReady); end
    checks++; if ((ifc.ReadRegister1 !== 5'd8) || (ifc.ReadRegister2 !== 5'd9)) begin
      errors++; $display("FAIL basic_readReg got %0d/%0d expected 8/9", ifc.ReadRegister1, ifc.ReadRegister2);
    end
    nextCycle();
    checks++; if (ifc.OutValid !== 1'b1) begin errors++; $display("FAIL basic_outValid got %b expected 1", ifc.OutValid); end
    checks++; if (ifc.OpA !== 32'h11) begin errors++; $display("FAIL basic_opA got %h expected 11", ifc.OpA); end
    checks++; if (ifc.OpB !== 32'h22) begin errors++; $display("FAIL basic_opB got %h expected 22", ifc.OpB); end
    ifc.Instruction = mk(5'd9, 5'd8, 16'h2);
    #1;
    checks++; if (ifc.InReady !== 1'b1) begin errors++; $display("FAIL b2b_inReady got %b expected 1", ifc.InReady); end
    nextCycle();
    checks++; if ((ifc.OpA !== 32'h22) || (ifc.OpB !== 32'h11)) begin
      errors++; $display("FAIL b2b_ops got %h/%h expected 22/11", ifc.OpA, ifc.OpB);
    end
    checks++; if (ifc.OutInstruction !== mk(5'd9, 5'd8, 16'h2)) begin
      errors++; $display("FAIL b2b_instr got %h expected %h", ifc.OutInstruction, mk(5'd9, 5'd8, 16'h2));
    end
    ifc.InValid = 1'b0;
    nextCycle();
    checks++; if (ifc.OutValid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b expected 0", ifc.OutValid); end
  endtask

  task automatic test_wb_conflict();
    nextCycle();
    ifc.InValid = 1'b1; ifc.Instruction = mk(5'd8, 5'd9, 16'h3);
    ifc.RegWrite = 1'b1; ifc.WriteRegister = 5'd8; ifc.WriteData = 32'hAB;
    #1;
`ifdef OPERAND_FETCH_BYPASS_EN
    checks++; if (ifc.InReady !== 1'b1) begin errors++; $display("FAIL wb_inReady got %b expected 1", ifc.InReady); end
    nextCycle();
    ifc.InValid = 1'b0; ifc.RegWrite = 1'b0;
    checks++; if (ifc.StallCount !== 16'd0) begin errors++; $display("FAIL wb_stall got %0d expected 0", ifc.StallCount); end
`else
    checks++; if (ifc.InReady !== 1'b0) begin errors++; $display("FAIL wb_inReady got %b expected 0", ifc.InReady); end
    nextCycle();
    ifc.RegWrite = 1'b0;
    #1;
    checks++; if (ifc.InReady !== 1'b1) begin errors++; $display("FAIL wb_inReady2 got %b expected 1", ifc.InReady); end
    checks++; if (ifc.StallCount !== 16'd1) begin errors++; $display("FAIL wb_stall got %0d expected 1", ifc.StallCount); end
    nextCycle();
    ifc.InValid = 1'b0;
`endif
    checks++; if (ifc.OutValid !== 1'b1) begin errors++; $display("FAIL wb_outValid got %b expected 1", ifc.OutValid); end
    checks++; if (ifc.OpA !== 32'hAB) begin errors++; $display("FAIL wb_opA got %h expected ab", ifc.OpA); end
    nextCycle();
  endtask

  task automatic test_r0();
    nextCycle();
    ifc.InValid = 1'b1; ifc.Instruction = mk(5'd0, 5'd9, 16'h4);
    ifc.RegWrite = 1'b1; ifc.WriteRegister = 5'd0; ifc.WriteData = 32'hFFFF_FFFF;
    #1;
    checks++; if (ifc.InReady !== 1'b1) begin errors++; $display("FAIL r0_inReady got %b expected 1", ifc.InReady); end
    nextCycle();
    ifc.InValid = 1'b0; ifc.OutReady = 1'b0;
    checks++; if (ifc.OpA !== 32'h0) begin errors++; $display("FAIL r0_opA got %h expected 0", ifc.OpA); end
    checks++; if (ifc.OpB !== 32'h22) begin errors++; $display("FAIL r0_opB got %h expected 22", ifc.OpB); end
    nextCycle();
    checks++; if ((ifc.OutValid !== 1'b1) || (ifc.OpA !== 32'h0)) begin
      errors++; $display("FAIL r0_hold got valid=%b A=%h expected valid=1 A=0", ifc.OutValid, ifc.OpA);
    end
    ifc.OutReady = 1'b1; ifc.RegWrite = 1'b0;
    nextCycle();
  endtask

  task automatic test_load_use();
    nextCycle();
    ifc.ExLoadValid = 1'b1; ifc.ExLoadRegister = 5'd9;
    ifc.InValid = 1'b1; ifc.Instruction = mk(5'd8, 5'd9, 16'h5);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ifc.InReady !== 1'b0) begin errors++; $display("FAIL ld_inReady cycle %0d got %b expected 0", i, ifc.InReady); end
      nextCycle();
    end
    ifc.ExLoadValid = 1'b0;
    #1;
    checks++; if (ifc.InReady !== 1'b1) begin errors++; $display("FAIL ld_release got %b expected 1", ifc.InReady); end
`ifdef OPERAND_FETCH_BYPASS_EN
    checks++; if (ifc.StallCount !== 16'd3) begin errors++; $display("FAIL ld_stall got %0d expected 3", ifc.StallCount); end
`else
    checks++; if (ifc.StallCount !== 16'd4) begin errors++; $display("FAIL ld_stall got %0d expected 4", ifc.StallCount); end
`endif
    nextCycle();
    ifc.InValid = 1'b0;
    checks++; if ((ifc.OutValid !== 1'b1) || (ifc.OpA !== 32'hAB) || (ifc.OpB !== 32'h22)) begin
      errors++; $display("FAIL ld_capture got valid=%b A=%h B=%h expected 1/ab/22", ifc.OutValid, ifc.OpA, ifc.OpB);
    end
    nextCycle();
  endtask

  task automatic test_backpressure();
    nextCycle();
    ifc.OutReady = 1'b0; ifc.InValid = 1'b1; ifc.Instruction = mk(5'd10, 5'd9, 16'h6);
    nextCycle();
    checks++; if ((ifc.OutValid !== 1'b1) || (ifc.OpB !== 32'h22)) begin
      errors++; $display("FAIL bp_fill got valid=%b B=%h expected 1/22", ifc.OutValid, ifc.OpB);
    end
    ifc.Instruction = mk(5'd8, 5'd10, 16'h7);
    ifc.RegWrite = 1'b1; ifc.WriteRegister = 5'd9; ifc.WriteData = 32'h5A;
    #1;
    checks++; if (ifc.InReady !== 1'b0) begin errors++; $display("FAIL bp_inReady got %b expected 0", ifc.InReady); end
    nextCycle();
    checks++; if ((ifc.OpB !== 32'h5A) || (ifc.OpA !== 32'h33)) begin
      errors++; $display("FAIL bp_holdUpdate got A=%h B=%h expected 33/5a", ifc.OpA, ifc.OpB);
    end
    checks++; if (ifc.OutInstruction !== mk(5'd10, 5'd9, 16'h6)) begin
      errors++; $display("FAIL bp_instrHeld got %h expected %h", ifc.OutInstruction, mk(5'd10, 5'd9, 16'h6));
    end
    ifc.RegWrite = 1'b0; ifc.OutReady = 1'b1;
    nextCycle();
    ifc.InValid = 1'b0;
    checks++; if ((ifc.OutValid !== 1'b1) || (ifc.OutInstruction !== mk(5'd8, 5'd10, 16'h7))) begin
      errors++; $display("FAIL bp_replace got valid=%b I=%h expected 1/%h", ifc.OutValid, ifc.OutInstruction, mk(5'd8, 5'd10, 16'h7));
    end
    checks++; if ((ifc.OpA !== 32'hAB) || (ifc.OpB !== 32'h33)) begin
      errors++; $display("FAIL bp_replaceOps got A=%h B=%h expected ab/33", ifc.OpA, ifc.OpB);
    end
    nextCycle();
  endtask

  task automatic test_reset_mid();
    nextCycle();
    ifc.ExLoadValid = 1'b1; ifc.ExLoadRegister = 5'd8; ifc.OutReady = 1'b0;
    ifc.InValid = 1'b1; ifc.Instruction = mk(5'd8, 5'd9, 16'h8);
    nextCycle();
    nextCycle();
    ifc.ExLoadValid = 1'b0;
    nextCycle();
    ifc.InValid = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
    checks++; if (ifc.StallCount !== 16'd5) begin errors++; $display("FAIL mid_stallPre got %0d expected 5", ifc.StallCount); end
`else
    checks++; if (ifc.StallCount !== 16'd6) begin errors++; $display("FAIL mid_stallPre got %0d expected 6", ifc.StallCount); end
`endif
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checks++; if (ifc.OutValid !== 1'b0) begin errors++; $display("FAIL mid_outValid got %b expected 0", ifc.OutValid); end
    checks++; if ((ifc.OpA !== 32'h0) || (ifc.OpB !== 32'h0)) begin
      errors++; $display("FAIL mid_ops got %h/%h expected 0/0", ifc.OpA, ifc.OpB);
    end
    checks++; if (ifc.StallCount !== 16'h0) begin errors++; $display("FAIL mid_stall got %0d expected 0", ifc.StallCount); end
    checks++; if (ifc.InReady !== 1'b1) begin errors++; $display("FAIL mid_inReady got %b expected 1", ifc.InReady); end
    nextCycle();
    Reset_n = 1'b1; ifc.OutReady = 1'b1;
    nextCycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      nextCycle();
      if (!lastStalled) begin
        ifc.InValid     = 1'($urandom_range(0, 1));
        ifc.Instruction = mk(pick(int'($urandom_range(0, 4))), pick(int'($urandom_range(0, 4))), 16'(c));
      end
      ifc.RegWrite       = ($urandom_range(0, 2) == 0);
      ifc.WriteRegister  = pick(int'($urandom_range(0, 4)));
      ifc.WriteData      = $urandom();
      ifc.ExLoadValid    = ($urandom_range(0, 3) == 0);
      ifc.ExLoadRegister = pick(int'($urandom_range(0, 4)));
      ifc.OutReady       = ($urandom_range(0, 3) != 0);
    end
    nextCycle();
    idle();
    repeat (3) nextCycle();
  endtask

  initial begin
    Reset_n = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_wb_conflict();
    test_r0();
    test_load_use();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage of the MIPS datapath, directly upstream of execute and the consumer of the register file's two asynchronous read ports. Accepts one instruction per cycle over a valid/ready handshake, drives the rs/rt read addresses, and resolves same-cycle writeback conflicts. Stalls on load-use hazards and holds captured operands in a single-entry output register until execute takes them.

## Interface
Parameters:
- none

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- InValid  in  1  upstream instruction valid
- InReady  out  1  stage can accept this cycle
- Instruction  in  32  instruction word; rs = [25:21], rt = [20:16]
- ReadRegister1  out  5  to regfile; combinational Instruction[25:21]
- ReadRegister2  out  5  to regfile; combinational Instruction[20:16]
- ReadData1  in  32  regfile contents of rs
- ReadData2  in  32  regfile contents of rt
- WriteRegister  in  5  writeback address, same net as regfile input
- WriteData  in  32  writeback data, same net as regfile input
- RegWrite  in  1  writeback enable, same net as regfile input
- ExLoadValid  in  1  execute stage holds a load
- ExLoadRegister  in  5  destination of that load
- OutValid  out  1  OpA/OpB/OutInstruction valid
- OutReady  in  1  execute accepts this cycle
- OpA  out  32  rs operand, registered
- OpB  out  32  rt operand, registered
- OutInstruction  out  32  captured instruction, registered
- StallCount  out  16  saturating count of hazard-stall cycles

## Operation
- Two states: EMPTY (OutValid=0) and FULL (OutValid=1).
- wbHit(r) = RegWrite && WriteRegister==r && r!=0.
- loadHazard = ExLoadValid && ExLoadRegister!=0 && (ExLoadRegister==rs || ExLoadRegister==rt). Both fields are compared for every opcode.
- hazard = loadHazard, plus the writeback-conflict term defined under Configuration.
- InReady = (!OutValid || OutReady) && !hazard. This is combinational.
- Accept = InValid && InReady. On accept:
  - OpA <= (rs==0) ? 0 : wbHit(rs) ? WriteData : ReadData1.
  - OpB is captured the same way from rt.
  - OutInstruction <= Instruction.
  - OutValid <= 1.
- Drain without accept (OutValid && OutReady && !Accept): OutValid <= 0. Data registers hold their last values.
- Accept and drain in the same cycle: the stage stays FULL with the new contents.
- Hold-update while FULL and not draining:
  - If wbHit(held rs), OpA <= WriteData.
  - If wbHit(held rt), OpB <= WriteData.
  - Both may update in the same cycle. A write to r0 never updates either operand.
- StallCount increments on every cycle with InValid && hazard. It saturates at 16'hFFFF.
- Reset (asynchronous, any time, including mid-stall or FULL):
  - OutValid=0, OpA=0, OpB=0, OutInstruction=0, StallCount=0.
  - InReady follows its combinational equation with OutValid=0.

## Timing
- Latency is 1 cycle from accept to OutValid.
- Throughput is 1 instruction per cycle when OutReady is held high and no hazard occurs.
- ReadRegister1/2 are combinational from Instruction. The regfile read is combinational, so the full path lies within one cycle.
- A load-use hazard holds InReady low for as long as ExLoadValid matches. The upstream stage must hold Instruction stable while InValid=1 and InReady=0.
- OutValid, once asserted, is not deasserted until OutReady=1.
- While FULL, OpA and OpB may change only through the hold-update rule. OutInstruction does not change.

## Configuration
- OPERAND_FETCH_BYPASS_EN defined:
  - wbHit forwarding is applied at accept.
  - A writeback conflict never stalls.
- OPERAND_FETCH_BYPASS_EN undefined:
  - A writeback conflict is an extra hazard term: hazard |= wbHit(rs) || wbHit(rt).
  - The stage stalls one cycle, then reads the committed regfile value.
  - StallCount counts these cycles.
  - Hold-update remains in both builds.

## Test plan
- **Basic accept/drain.** Reset; regfile r8=0x11, r9=0x22; send rs=8, rt=9 with OutReady=1 -> next cycle OutValid=1, OpA=0x11, OpB=0x22; InReady=1 every cycle.
- **Writeback conflict.** Same cycle as accept: RegWrite=1, WriteRegister=8, WriteData=0xAB.
  - Bypass build: OpA=0xAB, no stall.
  - Non-bypass build: InReady=0 for 1 cycle, then OpA=0xAB; StallCount=1.
- **r0 protection.** rs=0, RegWrite=1, WriteRegister=0, WriteData=0xFFFFFFFF -> OpA=0.
  - Hold FULL while writing r0 -> OpA stays 0.
- **Load-use stall.** ExLoadValid=1, ExLoadRegister=9, instruction rt=9 for 3 cycles -> InReady=0 for 3 cycles, StallCount=3. Drop ExLoadValid -> accepted next edge.
- **Backpressure hold-update.** FULL with OpB from r9=0x22, OutReady=0; write r9=0x5A -> OpB=0x5A, InReady=0. Then OutReady=1 together with a new InValid -> stays FULL with the new instruction.
- **Reset mid-operation.** Assert Reset_n=0 while FULL and StallCount=5 -> OutValid=0, OpA=OpB=0, StallCount=0 immediately, without waiting for a clock edge.
